// File: rtl/cls_sched.sv
// cls_sched - time-step scheduler and decision unit for the two-neuron
// output (classification) layer.
//
// Per inference: windowed per-step enable for the output layer (RUN), wait
// out the layer pipeline (DRAIN), compare the two potentials (DECIDE),
// present the decision over valid/ready (HOLD), then clear the layer (CLEAR).
//
// Parameters:
//   T_STEPS      time steps per inference (1..7)
//   STEP_CYCLES  clock cycles per time step (>= 2)
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   start           begin an inference (honoured only in IDLE)
//   busy            state is not IDLE
//   en_h            output-layer enable, first cycle of each step
//   step_idx        current step index
//   clr_h           one-cycle clear pulse to the output-layer potentials
//   potential1_h    accumulated potential, class 0 neuron
//   potential2_h    accumulated potential, class 1 neuron
//   cls_valid       decision valid
//   cls_ready       consumer accepts the decision
//   cls_id          0 = neuron1, 1 = neuron2, 3 = reject (tie)
//   score           winning potential
//
// Build option:
//   CLS_TIE_REJECT_EN  when defined, a tie yields cls_id = 3; otherwise 0.

module cls_sched #(
    parameter int unsigned T_STEPS     = 4,
    parameter int unsigned STEP_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       busy,
    output logic       en_h,
    output logic [2:0] step_idx,
    output logic       clr_h,
    input  logic [2:0] potential1_h,
    input  logic [2:0] potential2_h,
    output logic       cls_valid,
    input  logic       cls_ready,
    output logic [1:0] cls_id,
    output logic [2:0] score
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_RUN    = 3'd1;
    localparam logic [2:0] S_DRAIN  = 3'd2;
    localparam logic [2:0] S_DECIDE = 3'd3;
    localparam logic [2:0] S_HOLD   = 3'd4;
    localparam logic [2:0] S_CLEAR  = 3'd5;

    localparam int unsigned CW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(STEP_CYCLES - 1);
    localparam logic [2:0]    STEP_LAST = 3'(T_STEPS - 1);

`ifdef CLS_TIE_REJECT_EN
    localparam logic [1:0] TIE_ID = 2'd3;
`else
    localparam logic [1:0] TIE_ID = 2'd0;
`endif

    logic [2:0]    state, nxt_state;
    logic [CW-1:0] cnt, nxt_cnt;
    logic [2:0]    nxt_step;
    logic [1:0]    drain, nxt_drain;
    logic [1:0]    nxt_id;
    logic [2:0]    nxt_score;

    always_comb begin
        nxt_state = state;
        nxt_cnt   = cnt;
        nxt_step  = step_idx;
        nxt_drain = drain;
        nxt_id    = cls_id;
        nxt_score = score;
        case (state)
            S_IDLE: begin
                if (start) begin
                    nxt_state = S_RUN;
                    nxt_cnt   = '0;
                    nxt_step  = '0;
                end
            end
            S_RUN: begin
                if (cnt == CNT_LAST) begin
                    nxt_cnt = '0;
                    if (step_idx == STEP_LAST) begin
                        nxt_state = S_DRAIN;
                        nxt_step  = '0;
                        nxt_drain = '0;
                    end else begin
                        nxt_step = step_idx + 3'd1;
                    end
                end else begin
                    nxt_cnt = cnt + CW'(1);
                end
            end
            S_DRAIN: begin
                // Two edge-pipeline stages plus the potential register.
                if (drain == 2'd2) begin
                    nxt_state = S_DECIDE;
                end else begin
                    nxt_drain = drain + 2'd1;
                end
            end
            S_DECIDE: begin
                nxt_state = S_HOLD;
                if (potential1_h > potential2_h) begin
                    nxt_id    = 2'd0;
                    nxt_score = potential1_h;
                end else if (potential2_h > potential1_h) begin
                    nxt_id    = 2'd1;
                    nxt_score = potential2_h;
                end else begin
                    nxt_id    = TIE_ID;
                    nxt_score = potential1_h;
                end
            end
            S_HOLD: begin
                if (cls_valid && cls_ready) begin
                    nxt_state = S_CLEAR;
                end
            end
            S_CLEAR: begin
                nxt_state = S_IDLE;
            end
            default: begin
                nxt_state = S_IDLE;
            end
        endcase
    end

    // Outputs are flopped from the next-state values so each one lines up
    // with the state it describes while still coming straight off a register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            drain     <= '0;
            busy      <= 1'b0;
            en_h      <= 1'b0;
            step_idx  <= '0;
            clr_h     <= 1'b0;
            cls_valid <= 1'b0;
            cls_id    <= '0;
            score     <= '0;
        end else begin
            state     <= nxt_state;
            cnt       <= nxt_cnt;
            drain     <= nxt_drain;
            busy      <= (nxt_state != S_IDLE);
            en_h      <= (nxt_state == S_RUN) && (nxt_cnt == '0);
            step_idx  <= nxt_step;
            clr_h     <= (nxt_state == S_CLEAR);
            cls_valid <= (nxt_state == S_HOLD);
            cls_id    <= nxt_id;
            score     <= nxt_score;
        end
    end

endmodule
